// File: rtl/vga_frame_scanout.sv
// Purpose: 160x120x24 frame buffer written from the drawing side and scanned out
//          as 640x480@60 VGA with each stored pixel shown as a 4x4 block.
// Latency: outputs lag the scan counters by one pixel (2 CLOCK_50 cycles); writes
//          land in one cycle. Backpressure: none; while busy (post-reset clear),
//          plot writes are dropped.
//
// Ports:
//   CLOCK_50, resetn          50 MHz clock, synchronous active-low reset
//   VGA_X, VGA_Y, VGA_COLOR   write coordinate (0..159, 0..119) and {R,G,B} colour
//   plot                      write strobe, one write per cycle while high
//   busy                      high while the buffer is being cleared
//   vga_r/g/b                 pixel colour to the DAC
//   vga_hs, vga_vs            active-low syncs
//   vga_blank_n               high in the visible region
//   vga_sync_n                tied low
//   vga_clk                   25 MHz pixel clock (the internal pixel enable)
module vga_frame_scanout #(
    parameter logic [23:0] BG_COLOR = 24'h000000,
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic [7:0]  VGA_X,
    input  logic [6:0]  VGA_Y,
    input  logic [23:0] VGA_COLOR,
    input  logic        plot,
    output logic        busy,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vga_sync_n,
    output logic        vga_clk
);

    localparam logic [9:0]  H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]  H_VIS_C  = 10'(H_VIS);
    localparam logic [9:0]  V_VIS_C  = 10'(V_VIS);
    localparam logic [9:0]  HS_START = 10'(H_VIS + H_FP);
    localparam logic [9:0]  HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]  VS_START = 10'(V_VIS + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [14:0] FB_DEPTH = 15'd19200;
    localparam logic [14:0] FB_LAST  = 15'd19199;

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t      state, state_nxt;
    logic [14:0] clr_addr;
    logic        pix_en;
    logic [9:0]  hcnt, vcnt;

    logic        wr_en;
    logic [14:0] wr_addr;
    logic [23:0] wr_dat;
    logic [14:0] plot_addr, rd_addr;
    logic        plot_in_range;
    logic [23:0] rd_dat;
    logic        vis_raw, hs_raw, vs_raw;

    logic [23:0] mem [0:19199];

    // ---------------- clear FSM ----------------
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state <= S_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_CLEAR: if (clr_addr == FB_LAST) state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_CLEAR;
        endcase
    end

    // The write port is shared: the clear owns it in CLEAR, the drawing side in RUN.
    always_comb begin
        busy    = (state == S_CLEAR);
        wr_en   = 1'b0;
        wr_addr = clr_addr;
        wr_dat  = BG_COLOR;
        case (state)
            S_CLEAR: wr_en = 1'b1;
            S_RUN: begin
                wr_en   = plot && plot_in_range;
                wr_addr = plot_addr;
                wr_dat  = VGA_COLOR;
            end
            default: wr_en = 1'b0;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            clr_addr <= '0;
        end else if (state == S_CLEAR) begin
            clr_addr <= clr_addr + 15'd1;
        end
    end

    // ---------------- address arithmetic: y*160 + x as shifts ----------------
    always_comb begin
        logic [14:0] wy, ry;
        wy            = {8'd0, VGA_Y};
        plot_addr     = (wy << 7) + (wy << 5) + {7'd0, VGA_X};
        plot_in_range = (VGA_X < 8'd160) && (VGA_Y < 7'd120);
        ry            = {7'd0, vcnt[9:2]};
        rd_addr       = (ry << 7) + (ry << 5) + {7'd0, hcnt[9:2]};
    end

    // ---------------- frame buffer ----------------
    // Read every cycle: the address for pixel k is stable from the cycle the
    // counters move to k, so the data is ready by the next pixel-enable edge.
    // A read of the address written in the same cycle returns the old word.
    // Addresses past the buffer only occur in blanking and read as zero.
    always_ff @(posedge CLOCK_50) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        rd_dat <= (rd_addr < FB_DEPTH) ? mem[rd_addr] : '0;
    end

    // ---------------- scan timing ----------------
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            pix_en <= 1'b0;
        end else begin
            pix_en <= ~pix_en;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (pix_en) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
            end else begin
                hcnt <= hcnt + 10'd1;
            end
        end
    end

    always_comb begin
        vis_raw = (hcnt < H_VIS_C) && (vcnt < V_VIS_C);
        hs_raw  = ~((hcnt >= HS_START) && (hcnt < HS_END));
        vs_raw  = ~((vcnt >= VS_START) && (vcnt < VS_END));
    end

    // Single pixel-wide output stage: syncs, blank and colour all move together.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
        end else if (pix_en) begin
            vga_hs      <= hs_raw;
            vga_vs      <= vs_raw;
            vga_blank_n <= vis_raw;
            if (vis_raw && (state == S_RUN)) begin
                {vga_r, vga_g, vga_b} <= rd_dat;
            end else begin
                {vga_r, vga_g, vga_b} <= '0;
            end
        end
    end

    assign vga_sync_n = 1'b0;
    assign vga_clk    = pix_en;

endmodule

// File: doc/vga_frame_scanout.md
Name: vga_frame_scanout

Overview:
- Consumer end of the pixel-write interface: accepts (VGA_X, VGA_Y, VGA_COLOR, plot) writes from the drawing logic into a 160x120 frame buffer.
- Continuously scans the buffer out as 640x480@60 Hz VGA, with each stored pixel replicated 4x4.
- On reset, it clears the buffer to a background colour before accepting writes.
- Sits between the Tetris renderer and the board DAC/VGA pins.

Parameters:
- BG_COLOR, 24'h000000, colour written to every location during the post-reset clear.
- H_VIS/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixel clocks.
- V_VIS/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- resetn  in  1  synchronous, active-low reset.
- VGA_X  in  8  write column, 0..159.
- VGA_Y  in  7  write row, 0..119.
- VGA_COLOR  in  24  write colour, {R[7:0],G[7:0],B[7:0]}.
- plot  in  1  write strobe, one write per CLOCK_50 cycle while high.
- busy  out  1  high while the clear FSM runs; writes are ignored.
- vga_r, vga_g, vga_b  out  8 each  pixel colour to the DAC.
- vga_hs, vga_vs  out  1 each  syncs, active low.
- vga_blank_n  out  1  high during the visible region.
- vga_sync_n  out  1  tied 0.
- vga_clk  out  1  25 MHz pixel clock, equal to pix_en.

Behaviour:
- Reset: resetn is sampled on the CLOCK_50 rising edge; it is synchronous and active-low.
  - pix_en=0; hcnt=0; vcnt=0; clear address=0; FSM=CLEAR; busy=1.
  - vga_r/g/b=0; vga_hs=1; vga_vs=1; vga_blank_n=0.
- Pixel enable: pix_en toggles every CLOCK_50 cycle, going high on the first cycle after reset release. hcnt/vcnt advance only on pix_en=1 cycles.
- hcnt wraps 0..799. vcnt increments when hcnt wraps and itself wraps 0..524.
- Raw sync/blank, derived from counters:
  - hs low for hcnt 656..751.
  - vs low for vcnt 490..491.
  - visible when hcnt<640 && vcnt<480.
- Memory: 19200 x 24, simple dual-port.
  - Address = y*160 + x, computed as (y<<7)+(y<<5)+x, 15 bits.
  - Read latency 1 CLOCK_50 cycle.
  - Same-address read and write in one cycle returns old data.
- Write path, state RUN only: when plot=1 && VGA_X<160 && VGA_Y<120, write VGA_COLOR at the computed address that cycle.
  - Out-of-range coordinates are dropped silently.
  - No back-pressure exists; the writer may plot every cycle.
- Read path:
  - Read address = (vcnt>>2)*160 + (hcnt>>2), issued on the pix_en=1 cycle.
  - Read data is registered into vga_r/g/b on the next pix_en=1 cycle.
  - hs/vs/blank are delayed through one pixel-wide register stage so all outputs are aligned.
  - Outputs therefore lag the counters by exactly 1 pixel (2 CLOCK_50 cycles).
- Colour output rules:
  - vga_r/g/b = 0 whenever the delayed blank is inactive.
  - vga_r/g/b = 0 whenever FSM=CLEAR.
- FSM:
  - CLEAR: write BG_COLOR at the clear address each cycle and increment the address. After address 19199 is written, go to RUN on the next cycle; busy drops with that transition. Clear takes exactly 19200 cycles after reset release.
  - RUN: serve plot writes.
  - resetn low in any state returns to CLEAR with address 0.
  - Scan timing runs normally in both states; syncs are never suppressed.
- Reset mid-frame: counters restart at 0 and the clear restarts from address 0. Any partially cleared or drawn content is overwritten.

Test Plan:
- Sync timing: release reset, count CLOCK_50 edges -> vga_hs low for 192 cycles every 1600; vga_vs low for 2 lines (3200 cycles) every 525 lines (840000 cycles); vga_blank_n high for 1280 cycles per visible line.
- Clear: release reset -> busy high for exactly 19200 cycles, then low. Plot (10,10,24'hFF0000) while busy=1 -> pixel still reads BG_COLOR on the display.
- Write/scan: after busy=0, plot x=50,y=50,color=24'hFF0000 for one cycle -> vga_r=8'hFF, vga_g=0, vga_b=0 for display columns 200..203 on lines 200..203; all other visible pixels read BG_COLOR.
- Bounds: plot x=160,y=0 and x=0,y=120 with 24'hFFFFFF -> no memory change. Pixel (0,0) and the last pixel (159,119) still read BG_COLOR.
- Streaming: full-frame sweep with plot=1 every cycle, color=x-dependent -> each 4x4 block shows its x-dependent colour, with no dropped writes.
- Mid-operation reset: assert resetn=0 at vcnt=300 for 1 cycle -> hcnt/vcnt restart at 0, busy=1 again for 19200 cycles, and previously drawn pixels read BG_COLOR afterwards.
